reg64_piso_tx: RTL
==================

// Module: reg64_piso_tx
// PURPOSE
//   Parallel-in/serial-out transmitter and the outbound end of our 64-bit register path.
//   Accepts one WIDTH-bit word via a valid/ready handshake, then shifts it out one bit
//   per clk with frame-valid and last markers.
//   Sits after a 64-bit holding register; feeds a serial link or a matching deserializer.
// PARAMETERS
//   WIDTH      64  data word width in bits (>=2)
//   MSB_FIRST  0   0: bit 0 is sent first; 1: bit WIDTH-1 is sent first
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      reset, asynchronous, active-low
//   in_valid   in   1      in_data is valid this cycle
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   WIDTH  parallel word to transmit
//   ser_out    out  1      serial data bit (registered)
//   ser_valid  out  1      ser_out carries a frame bit this cycle (registered)
//   ser_last   out  1      current ser_out is the final bit of the frame (registered)
//   busy       out  1      a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, shift reg=0, count=0; ser_out=0, ser_valid=0, ser_last=0, busy=0.
//     in_ready=1 while in reset, but there is no capture while rst=0.
//   FSM states: IDLE, SHIFT (+ PARITY when PARITY_EN).
//     IDLE -> SHIFT when in_valid&&in_ready.
//     SHIFT -> IDLE after the last data bit, unless a new word is accepted (stay in SHIFT, count=0).
//     SHIFT -> PARITY instead, when PARITY_EN is defined.
//     PARITY -> IDLE, or -> SHIFT if a new word is accepted.
//   in_ready = (state==IDLE) | (final frame bit on ser_out this cycle). This gives gapless back-to-back frames.
//   Accept at posedge N: word loaded into the shift register.
//     First bit is on ser_out in cycle N+1; data bit k is in cycle N+1+k; last data bit is in cycle N+WIDTH.
//   ser_valid=1 for every frame bit and 0 otherwise. ser_out=0 whenever ser_valid=0.
//   ser_last=1 only on the final frame bit.
//   Counter width $clog2(WIDTH+1). Counter is compared to WIDTH-1 for the last data bit. No wrap past WIDTH.
//   in_valid while in_ready=0: ignored, no capture. The upstream holds in_data.
//   in_data changes after acceptance: no effect on the frame in flight.
//   Reset mid-frame: frame aborted immediately; outputs drop to reset values; no resume.
//     The next accepted word starts at bit 0.
// CONFIGURATION
//   PARITY_EN defined:
//     - Parity = XOR of all WIDTH data bits, captured at accept.
//     - One extra bit follows the last data bit: ser_valid=1, ser_out=parity, ser_last=1.
//     - Frame is WIDTH+1 cycles.
//     - ser_last is not asserted on data bit WIDTH-1.
//   PARITY_EN undefined:
//     - No PARITY state. Frame is WIDTH cycles.
//     - ser_last is on data bit WIDTH-1.
// STRUCTURE
//   Package reg_piso_pkg: state enum (IDLE, SHIFT, PARITY); default width constant DATA_W=64.
//   Sub-module piso_bit_counter: load/clear and increment; outputs is_last_data flag; async active-low reset.
//   Top holds FSM, shift register, parity register, and output registers.
// TESTING
//   1 Assert rst=0 mid-simulation with no clk edge -> ser_out=0, ser_valid=0, ser_last=0, busy=0 at once.
//   2 WIDTH=64, LSB-first, accept 64'h0000_0000_0000_0001 -> ser_out=1 in cycle 1, then 63 zeros.
//     ser_valid high 64 cycles; ser_last on cycle 64; in_ready=1 on cycle 64.
//   3 in_valid held high with words 64'hA5A5_A5A5_A5A5_A5A5 and 64'h0F0F_0F0F_0F0F_0F0F
//     -> 128 contiguous ser_valid cycles; second frame bit 0 immediately follows the first ser_last.
//   4 Pulse in_valid with 64'hDEAD_BEEF_0000_0000 at bit 10 of a frame -> ignored; frame completes unchanged.
//   5 rst=0 at bit 20 of a frame, then release and accept 64'h1 -> aborted frame; new frame bit0=1, 64 cycles.
//   6 PARITY_EN, accept 64'hFFFF_FFFF_FFFF_FFFE -> 65-cycle frame, bit 64=1 with ser_last.
//     Separately, MSB_FIRST=1 with 64'h8000_0000_0000_0000 -> first ser_out=1.

Source files
------------

// File: rtl/reg_piso_pkg.sv
// Shared types for the 64-bit register-path serializer: FSM state encoding and default data width.
package reg_piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DATA_W = 64;

endpackage

// File: rtl/reg64_piso_tx_bit_counter.sv
// Frame bit counter: value is the number of data bits already placed on ser_out (0..WIDTH, saturating).
// Zero latency on flags; no backpressure, driven entirely by the parent FSM.
module piso_bit_counter
  import reg_piso_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_clr,
  input  logic cnt_ld,
  input  logic cnt_inc,
  output logic is_last_data,
  output logic is_full
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A load always happens together with bit 0 going out, so it loads 1, not 0.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_ld) begin
      cnt_d = CW'(1);
    end else if (cnt_inc && (cnt_q != CW'(WIDTH))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last_data = (cnt_q == CW'(WIDTH - 1));
  assign is_full      = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/reg64_piso_tx.sv
// Parallel-in/serial-out transmitter: first bit on ser_out the cycle after accept, WIDTH (+1 parity) bits per frame.
// in_ready only in IDLE or on the final frame bit (gapless back-to-back); optional parity bit via `PARITY_EN.
module reg64_piso_tx
  import reg_piso_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_PARITY = PARITY;

`ifdef PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic             parity_q,    parity_d;
  logic             ser_out_q,   ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q,  ser_last_d;

  logic             cnt_clr, cnt_ld, cnt_inc;
  logic             cnt_last, cnt_full;
  logic             accept;
  logic             in_first, sh_bit;
  logic [WIDTH-1:0] in_rest,  sh_rest;

  // The shift register holds only the bits not yet presented; ser_out_q is the bit on the wire.
  assign in_first = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign in_rest  = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
  assign sh_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign sh_rest  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  assign in_ready = (state_q == S_IDLE) | ser_last_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_ld      = 1'b0;
    cnt_inc     = 1'b0;
    if (accept) begin
      state_d     = S_SHIFT;
      shift_d     = in_rest;
      parity_d    = ^in_data;
      ser_out_d   = in_first;
      ser_valid_d = 1'b1;
      cnt_ld      = 1'b1;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_full) begin
            if (PAR_EN) begin
              state_d     = S_PARITY;
              ser_out_d   = parity_q;
              ser_valid_d = 1'b1;
              ser_last_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              cnt_clr = 1'b1;
            end
          end else begin
            shift_d     = sh_rest;
            ser_out_d   = sh_bit;
            ser_valid_d = 1'b1;
            cnt_inc     = 1'b1;
            ser_last_d  = cnt_last & ~PAR_EN;
          end
        end
        S_PARITY: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .cnt_clr     (cnt_clr),
    .cnt_ld      (cnt_ld),
    .cnt_inc     (cnt_inc),
    .is_last_data(cnt_last),
    .is_full     (cnt_full)
  );

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q != S_IDLE);

endmodule
